sc_hdlc_stream2pkt: RTL and testbench
=====================================

# sc_hdlc_stream2pkt

Packet-side consumer for HDLC receive streams. It accepts the 8-bit AXI-Stream produced by the HDLC receive bridge, in which each frame is payload bytes followed by a 5-byte status/length trailer. It strips the trailer, re-emits the payload as a clean AXI-Stream with `tlast` on the last payload byte, and pushes one decoded status record per frame. It sits between the HDLC receive FIFO and the packet DMA/host interface.

## Interface
Parameters:
- None. Trailer size and flag layout are fixed constants in the shared package.

Ports:
- `clk`  in  1  Single clock for all logic.
- `rst`  in  1  Synchronous reset, active-high.
- `s_axis_tdata`  in  8  Frame byte.
- `s_axis_tvalid`  in  1  Upstream byte valid.
- `s_axis_tready`  out  1  Block can accept a byte.
- `s_axis_tlast`  in  1  Last trailer byte of the frame.
- `s_axis_tid`  in  5  Frame id; sampled on the first beat of each frame.
- `s_axis_tdest`  in  5  Frame destination; sampled on the first beat of each frame.
- `m_axis_tdata`  out  8  Payload byte.
- `m_axis_tvalid`  out  1  Payload byte valid.
- `m_axis_tready`  in  1  Downstream ready.
- `m_axis_tlast`  out  1  Last payload byte.
- `m_axis_tid`, `m_axis_tdest`  out  5 each  Values latched from the first beat of the frame.
- `m_axis_tuser`  out  1  On the `tlast` beat: `error | abort | len_mismatch`. 0 on all other beats.
- `sts_push`  out  1  One-cycle pulse; the status record below is valid.
- `sts_length`  out  32  Payload byte count, saturating.
- `sts_flags`  out  5  {runt, len_mismatch, abort, end, error}.

## Operation
- Trailer format, in arrival order:
  - T0 = {5'b0, abort, end, error}.
  - T1..T4 = LEN[31:24], LEN[23:16], LEN[15:8], LEN[7:0]. LEN is the total frame beats, trailer included.
- Buffering:
  - A 6-entry shift buffer (`cnt` 0..6) holds the newest bytes.
  - An accepted byte with `cnt<6` is pushed.
  - An accepted byte with `cnt==6` shifts the oldest entry into the output register as a non-last payload beat, then pushes the new byte.
- Output register free condition: `free = ~m_axis_tvalid | m_axis_tready`.
- `s_axis_tready = (state==STREAM) & (cnt<6 | free)`. This is combinational from `m_axis_tready`.
- A beat counter counts accepted bytes per frame and saturates at 0xFFFFFFFF.
- On the `tlast` beat, `n` = number of bytes held after the accept. The newest 5 bytes form the trailer.
  - `n==6`: one payload byte remains (buf[0]). Go to FLUSH.
  - `n==5`: zero-length payload. No `m_axis` beat is emitted.
  - `n<5`: runt frame. Bytes are dropped and `runt=1`; abort/end/error/len_mismatch are reported as 0.
- States:
  - STREAM: normal accept.
  - FLUSH: `s_axis_tready=0`. When `free`, load buf[0] with `tlast=1` and `tuser`, clear `cnt`, return to STREAM.
- Status record:
  - `sts_length = beats - 5` (0 for runt).
  - `len_mismatch = (LEN != beats)`.
  - `sts_push` fires exactly once per frame.
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`, `sts_push` = 0.
  - `m_axis_tdata`, `m_axis_tid`, `m_axis_tdest`, `sts_length`, `sts_flags` = 0.
  - `cnt=0`, `state=STREAM`.

## Timing
- `sts_push` asserts on the cycle after the `tlast` accept. This can precede the payload `tlast` beat when `m_axis` is stalled.
- Payload byte k appears on `m_axis` one cycle after byte k+6 is accepted. Minimum in-block buffering is 7 bytes (6 buffer + 1 output register).
- FLUSH lasts at least 1 cycle and holds while `m_axis_tready=0`. With `free` high, back-to-back frames lose exactly 1 input cycle.
- `m_axis` outputs hold stable while `tvalid & ~tready`.
- Reset mid-frame: the partial frame and any pending status are discarded. The remaining bytes of that frame are parsed as a new frame, normally reported as runt or mismatch. No resync is attempted.

## Configuration
- `HDLC_S2P_LEN_CHECK_EN` defined:
  - LEN is compared against the beat count.
  - A mismatch sets `len_mismatch` and `m_axis_tuser`.
- Undefined:
  - The comparator is removed and `len_mismatch` is constant 0.
  - T1..T4 are still consumed.
  - `sts_length` is still derived from the beat count.

## Structure
- Package `sc_hdlc_pkg`:
  - `HDLC_TRAILER_BYTES=5`.
  - Flag bit indices for T0 and `sts_flags`.
  - State encoding (STREAM, FLUSH).
- Sub-module `sc_hdlc_trailer_buf`:
  - 6×8 shift buffer with count, push/shift strobes.
  - Parallel view of the newest 5 bytes.
- The FSM, counters and AXI handshake stay in the top level.

## Test plan
- Good frame:
  - Stimulus: A1 A2 A3 02 00 00 00 08, `tlast` on 08, `tid=3`.
  - Response: `m_axis` A1 A2 A3, `tlast` on A3, `tuser=0`, `tid=3`; `sts_length=3`, `sts_flags=00010`.
- Zero-length frame:
  - Stimulus: 02 00 00 00 05.
  - Response: no `m_axis` beat; one `sts_push`, `sts_length=0`, `flags=00010`.
- Runt frame:
  - Stimulus: 3 bytes with `tlast`.
  - Response: no output; `sts_flags=10000`, `sts_length=0`.
- Length mismatch:
  - Stimulus: B0 B1 05 00 00 00 09.
  - Response: with `_EN`, `tuser=1` on B1 and `flags=01101`; without `_EN`, `flags=00101`.
- Backpressure:
  - Stimulus: 20-byte payload frame, `m_axis_tready=0` for 12 cycles mid-frame.
  - Response: `s_axis_tready` drops with 7 bytes held; no loss or duplication; FLUSH waits for `tready`.
- Reset mid-frame:
  - Stimulus: `rst=1` for 1 cycle after 4 payload bytes.
  - Response: all outputs return to 0, `cnt=0`; the next complete frame is parsed correctly.

Source files
------------

// File: rtl/sc_hdlc_pkg.sv
// Shared constants for the HDLC stream-to-packet path: trailer size, flag
// bit positions in T0 and in the status record, and FSM state encoding.
package sc_hdlc_pkg;

  localparam int HDLC_TRAILER_BYTES = 5;
  localparam int HDLC_BUF_DEPTH     = HDLC_TRAILER_BYTES + 1;

  // Bit positions inside trailer byte T0.
  localparam int T0_ERROR = 0;
  localparam int T0_END   = 1;
  localparam int T0_ABORT = 2;

  // Bit positions inside sts_flags.
  localparam int STS_ERROR        = 0;
  localparam int STS_END          = 1;
  localparam int STS_ABORT        = 2;
  localparam int STS_LEN_MISMATCH = 3;
  localparam int STS_RUNT         = 4;

  localparam logic [0:0] ST_STREAM = 1'b0;
  localparam logic [0:0] ST_FLUSH  = 1'b1;

  typedef logic [HDLC_TRAILER_BYTES-1:0][7:0] trailer_view_t;

endpackage

// File: rtl/sc_hdlc_trailer_buf.sv
// Six-byte shift buffer holding the newest bytes of a frame; exposes the
// oldest entry and a parallel view of the newest five held bytes.
module sc_hdlc_trailer_buf
  import sc_hdlc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          clear,
  input  logic [7:0]    data,
  output logic [2:0]    cnt,
  output logic [7:0]    oldest,
  output trailer_view_t newest
);

  logic [7:0] mem_reg [HDLC_BUF_DEPTH];
  logic [2:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 3'd0;
    end else if (clear) begin
      cnt_reg <= 3'd0;
    end else if (push) begin
      if (cnt_reg == 3'(HDLC_BUF_DEPTH)) begin
        // Full: oldest entry leaves (caller captures it), everything moves down.
        for (int i = 0; i < HDLC_BUF_DEPTH - 1; i++) begin
          mem_reg[i] <= mem_reg[i+1];
        end
        mem_reg[HDLC_BUF_DEPTH-1] <= data;
      end else begin
        mem_reg[cnt_reg] <= data;
        cnt_reg          <= cnt_reg + 3'd1;
      end
    end
  end

  assign cnt    = cnt_reg;
  assign oldest = mem_reg[0];

  // newest[HDLC_TRAILER_BYTES-1] is the most recent byte; missing slots read 0.
  generate
    for (genvar gi = 0; gi < HDLC_TRAILER_BYTES; gi++) begin : g_view
      localparam logic [2:0] OFF = 3'(HDLC_TRAILER_BYTES - gi);
      assign newest[gi] = (cnt_reg >= OFF) ? mem_reg[cnt_reg - OFF] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/sc_hdlc_stream2pkt.sv
// Strips the 5-byte HDLC status/length trailer from each received frame,
// re-emits the payload with tlast, and pushes one status record per frame.
// Optional LEN checking is enabled by defining HDLC_S2P_LEN_CHECK_EN.
module sc_hdlc_stream2pkt
  import sc_hdlc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [4:0]  s_axis_tid,
  input  logic [4:0]  s_axis_tdest,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [4:0]  m_axis_tid,
  output logic [4:0]  m_axis_tdest,
  output logic        m_axis_tuser,
  output logic        sts_push,
  output logic [31:0] sts_length,
  output logic [4:0]  sts_flags
);

  logic [0:0]    state_reg;
  logic [2:0]    buf_cnt;
  logic [7:0]    buf_oldest;
  trailer_view_t buf_newest;

  logic [31:0] beats_reg;
  logic [31:0] beats_next;
  logic [4:0]  tid_reg;
  logic [4:0]  tdest_reg;
  logic        tuser_pend_reg;

  logic [7:0]  m_tdata_reg;
  logic        m_tvalid_reg;
  logic        m_tlast_reg;
  logic        m_tuser_reg;
  logic [4:0]  m_tid_reg;
  logic [4:0]  m_tdest_reg;

  logic        sts_push_reg;
  logic [31:0] sts_length_reg;
  logic [4:0]  sts_flags_reg;

  logic        free;
  logic        accept;
  logic        shift;
  logic        flush_load;
  logic        buf_push;
  logic        buf_clear;
  logic [2:0]  n_held;
  logic        has_tail;
  logic        is_runt;
  logic [7:0]  t0;
  logic        len_mismatch;
  logic        frame_err;
  logic [4:0]  flags_next;
  logic        unused_view;

  assign free          = ~m_tvalid_reg | m_axis_tready;
  assign s_axis_tready = (state_reg == ST_STREAM) & ((buf_cnt < 3'(HDLC_BUF_DEPTH)) | free);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign shift         = accept & (buf_cnt == 3'(HDLC_BUF_DEPTH));
  assign flush_load    = (state_reg == ST_FLUSH) & free;

  // Bytes held once the current beat is in; decides payload tail / zero-length / runt.
  assign n_held   = (buf_cnt == 3'(HDLC_BUF_DEPTH)) ? 3'(HDLC_BUF_DEPTH) : buf_cnt + 3'd1;
  assign has_tail = (n_held == 3'(HDLC_BUF_DEPTH));
  assign is_runt  = (n_held < 3'(HDLC_TRAILER_BYTES));

  assign buf_push  = accept & ~(s_axis_tlast & ~has_tail);
  assign buf_clear = (accept & s_axis_tlast & ~has_tail) | flush_load;

  assign beats_next = (&beats_reg) ? beats_reg : beats_reg + 32'd1;

  // Before the tlast byte is stored, T0..T3 are the four newest held bytes.
  assign t0 = buf_newest[1];

`ifdef HDLC_S2P_LEN_CHECK_EN
  assign len_mismatch = ({buf_newest[2], buf_newest[3], buf_newest[4], s_axis_tdata} != beats_next);
  assign unused_view  = ^{buf_newest[0], t0[7:3]};
`else
  assign len_mismatch = 1'b0;
  assign unused_view  = ^{buf_newest[0], t0[7:3], buf_newest[2], buf_newest[3], buf_newest[4]};
`endif

  assign frame_err = t0[T0_ERROR] | t0[T0_ABORT] | len_mismatch;

  always_comb begin
    flags_next = 5'd0;
    if (is_runt) begin
      flags_next[STS_RUNT] = 1'b1;
    end else begin
      flags_next[STS_ERROR]        = t0[T0_ERROR];
      flags_next[STS_END]          = t0[T0_END];
      flags_next[STS_ABORT]        = t0[T0_ABORT];
      flags_next[STS_LEN_MISMATCH] = len_mismatch;
    end
  end

  sc_hdlc_trailer_buf u_buf (
    .clk    (clk),
    .rst    (rst),
    .push   (buf_push),
    .clear  (buf_clear),
    .data   (s_axis_tdata),
    .cnt    (buf_cnt),
    .oldest (buf_oldest),
    .newest (buf_newest)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_STREAM;
      beats_reg      <= 32'd0;
      tid_reg        <= 5'd0;
      tdest_reg      <= 5'd0;
      tuser_pend_reg <= 1'b0;
      m_tdata_reg    <= 8'd0;
      m_tvalid_reg   <= 1'b0;
      m_tlast_reg    <= 1'b0;
      m_tuser_reg    <= 1'b0;
      m_tid_reg      <= 5'd0;
      m_tdest_reg    <= 5'd0;
      sts_push_reg   <= 1'b0;
      sts_length_reg <= 32'd0;
      sts_flags_reg  <= 5'd0;
    end else begin
      sts_push_reg <= 1'b0;

      if (accept) begin
        if (beats_reg == 32'd0) begin
          tid_reg   <= s_axis_tid;
          tdest_reg <= s_axis_tdest;
        end
        if (s_axis_tlast) begin
          beats_reg      <= 32'd0;
          sts_push_reg   <= 1'b1;
          sts_flags_reg  <= flags_next;
          sts_length_reg <= is_runt ? 32'd0 : beats_next - 32'(HDLC_TRAILER_BYTES);
          tuser_pend_reg <= frame_err;
          if (has_tail) begin
            state_reg <= ST_FLUSH;
          end
        end else begin
          beats_reg <= beats_next;
        end
      end

      if (shift) begin
        m_tdata_reg  <= buf_oldest;
        m_tvalid_reg <= 1'b1;
        m_tlast_reg  <= 1'b0;
        m_tuser_reg  <= 1'b0;
        m_tid_reg    <= tid_reg;
        m_tdest_reg  <= tdest_reg;
      end else if (flush_load) begin
        m_tdata_reg  <= buf_oldest;
        m_tvalid_reg <= 1'b1;
        m_tlast_reg  <= 1'b1;
        m_tuser_reg  <= tuser_pend_reg;
        m_tid_reg    <= tid_reg;
        m_tdest_reg  <= tdest_reg;
        state_reg    <= ST_STREAM;
      end else if (m_axis_tready) begin
        m_tvalid_reg <= 1'b0;
        m_tlast_reg  <= 1'b0;
        m_tuser_reg  <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = m_tdata_reg;
  assign m_axis_tvalid = m_tvalid_reg;
  assign m_axis_tlast  = m_tlast_reg;
  assign m_axis_tuser  = m_tuser_reg;
  assign m_axis_tid    = m_tid_reg;
  assign m_axis_tdest  = m_tdest_reg;
  assign sts_push      = sts_push_reg;
  assign sts_length    = sts_length_reg;
  assign sts_flags     = sts_flags_reg;

endmodule

// File: tb/tb_sc_hdlc_stream2pkt.sv
// Directed bench for sc_hdlc_stream2pkt: good, zero-length, runt, mismatch,
// backpressure and mid-frame reset frames with hand-computed expectations.
module tb_sc_hdlc_stream2pkt;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [4:0]  s_axis_tid;
  logic [4:0]  s_axis_tdest;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [4:0]  m_axis_tid;
  logic [4:0]  m_axis_tdest;
  logic        m_axis_tuser;
  logic        sts_push;
  logic [31:0] sts_length;
  logic [4:0]  sts_flags;

  int total = 0;
  int bad   = 0;

  logic [7:0]  q_data[$];
  logic        q_last[$];
  logic        q_user[$];
  logic [4:0]  q_tid[$];
  logic [4:0]  q_tdest[$];
  logic [31:0] q_len[$];
  logic [4:0]  q_flags[$];

  always #5 clk = ~clk;

  sc_hdlc_stream2pkt dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tdest  (s_axis_tdest),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tuser  (m_axis_tuser),
    .sts_push      (sts_push),
    .sts_length    (sts_length),
    .sts_flags     (sts_flags)
  );

  // Inputs only change just after posedge, so the negedge view is what the next edge uses.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        q_data.push_back(m_axis_tdata);
        q_last.push_back(m_axis_tlast);
        q_user.push_back(m_axis_tuser);
        q_tid.push_back(m_axis_tid);
        q_tdest.push_back(m_axis_tdest);
        $display("beat data=%02h last=%0b user=%0b tid=%0d tdest=%0d",
                 m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tid, m_axis_tdest);
      end
      if (sts_push) begin
        q_len.push_back(sts_length);
        q_flags.push_back(sts_flags);
        $display("status length=%0d flags=%05b", sts_length, sts_flags);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete(); q_last.delete(); q_user.delete();
    q_tid.delete(); q_tdest.delete(); q_len.delete(); q_flags.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int   guard;
    logic rdy;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      rdy = s_axis_tready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 100);
    if (!rdy) chk("send_accept", {31'd0, rdy}, 32'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // tid/tdest change after the first beat to confirm only the first beat is sampled.
  task automatic send_frame(input logic [7:0] f[$], input logic [4:0] id, input logic [4:0] dst);
    for (int i = 0; i < f.size(); i++) begin
      s_axis_tid   = (i == 0) ? id  : ~id;
      s_axis_tdest = (i == 0) ? dst : ~dst;
      send(f[i], (i == f.size() - 1));
    end
  endtask

  task automatic expect_pkt(input string tag, input logic [7:0] exp[$], input logic exp_user,
                            input logic [4:0] id, input logic [4:0] dst);
    chk({tag, "_beats"}, q_data.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q_data.size(); i++) begin
      chk({tag, "_data"}, q_data[i], exp[i]);
      chk({tag, "_last"}, q_last[i], (i == exp.size() - 1));
      chk({tag, "_user"}, q_user[i], (i == exp.size() - 1) ? exp_user : 1'b0);
      chk({tag, "_tid"}, q_tid[i], id);
      chk({tag, "_tdest"}, q_tdest[i], dst);
    end
  endtask

  task automatic expect_sts(input string tag, input logic [31:0] len, input logic [4:0] flags);
    chk({tag, "_sts_count"}, q_len.size(), 1);
    if (q_len.size() > 0) begin
      chk({tag, "_sts_len"}, q_len[0], len);
      chk({tag, "_sts_flags"}, q_flags[0], flags);
    end
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] exp[$];
    int         accepted;

    rst           = 1'b1;
    s_axis_tdata  = 8'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tid    = 5'd0;
    s_axis_tdest  = 5'd0;
    m_axis_tready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tuser", m_axis_tuser, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_sts_push", sts_push, 0);
    chk("rst_sts_length", sts_length, 0);
    chk("rst_sts_flags", sts_flags, 0);
    chk("rst_s_tready", s_axis_tready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Good frame: payload A1 A2 A3, LEN=8, T0=end.
    clear_q();
    fr = '{8'hA1, 8'hA2, 8'hA3, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08};
    send_frame(fr, 5'd3, 5'd7);
    @(negedge clk);
    chk("good_sts_push_timing", sts_push, 1);
    idle(10);
    exp = '{8'hA1, 8'hA2, 8'hA3};
    expect_pkt("good", exp, 1'b0, 5'd3, 5'd7);
    expect_sts("good", 32'd3, 5'b00010);

    // Zero-length payload.
    clear_q();
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h05};
    send_frame(fr, 5'd1, 5'd1);
    idle(10);
    chk("zero_beats", q_data.size(), 0);
    expect_sts("zero", 32'd0, 5'b00010);

    // Runt frame.
    clear_q();
    fr = '{8'h11, 8'h22, 8'h33};
    send_frame(fr, 5'd1, 5'd1);
    idle(10);
    chk("runt_beats", q_data.size(), 0);
    expect_sts("runt", 32'd0, 5'b10000);

    // Length mismatch: LEN=9 but 7 beats, T0 = abort|error.
    clear_q();
    fr = '{8'hB0, 8'hB1, 8'h05, 8'h00, 8'h00, 8'h00, 8'h09};
    send_frame(fr, 5'd2, 5'd5);
    idle(10);
    exp = '{8'hB0, 8'hB1};
    expect_pkt("mism", exp, 1'b1, 5'd2, 5'd5);
`ifdef HDLC_S2P_LEN_CHECK_EN
    expect_sts("mism", 32'd2, 5'b01101);
`else
    expect_sts("mism", 32'd2, 5'b00101);
`endif

    // Backpressure: 20-byte payload, downstream stalled while the frame starts.
    clear_q();
    fr.delete();
    exp.delete();
    for (int i = 0; i < 20; i++) begin
      fr.push_back(8'h40 + 8'(i));
      exp.push_back(8'h40 + 8'(i));
    end
    fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h00);
    fr.push_back(8'h00); fr.push_back(8'h19);
    m_axis_tready = 1'b0;
    accepted = 0;
    s_axis_tid   = 5'd6;
    s_axis_tdest = 5'd10;
    for (int c = 0; c < 12; c++) begin
      s_axis_tdata  = fr[accepted];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b0;
      @(negedge clk);
      if (s_axis_tready) accepted++;
      @(posedge clk);
      #1;
      s_axis_tid   = ~5'd6;
      s_axis_tdest = ~5'd10;
    end
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("bp_held_bytes", accepted, 7);
    chk("bp_s_tready", s_axis_tready, 0);
    chk("bp_m_tvalid", m_axis_tvalid, 1);
    chk("bp_m_tdata_hold", m_axis_tdata, 8'h40);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    for (int i = accepted; i < fr.size(); i++) begin
      send(fr[i], (i == fr.size() - 1));
    end
    m_axis_tready = 1'b0;
    idle(4);
    @(negedge clk);
    chk("flush_wait_tlast", m_axis_tlast, 0);
    chk("flush_wait_tdata", m_axis_tdata, 8'h52);
    chk("flush_wait_s_tready", s_axis_tready, 0);
    chk("flush_sts_early", q_len.size(), 1);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    idle(8);
    expect_pkt("bp", exp, 1'b0, 5'd6, 5'd10);
    expect_sts("bp", 32'd20, 5'b00000);

    // Reset after 4 payload bytes, then a clean frame.
    clear_q();
    fr = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    for (int i = 0; i < 4; i++) begin
      s_axis_tid   = 5'd9;
      s_axis_tdest = 5'd9;
      send(fr[i], 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_m_tvalid", m_axis_tvalid, 0);
    chk("mrst_m_tdata", m_axis_tdata, 0);
    chk("mrst_m_tid", m_axis_tid, 0);
    chk("mrst_m_tdest", m_axis_tdest, 0);
    chk("mrst_sts_length", sts_length, 0);
    chk("mrst_sts_push", sts_push, 0);
    chk("mrst_cnt", dut.buf_cnt, 0);
    @(posedge clk);
    #1;
    clear_q();
    fr = '{8'hC1, 8'hC2, 8'h02, 8'h00, 8'h00, 8'h00, 8'h07};
    send_frame(fr, 5'd4, 5'd2);
    idle(10);
    exp = '{8'hC1, 8'hC2};
    expect_pkt("after_rst", exp, 1'b0, 5'd4, 5'd2);
    expect_sts("after_rst", 32'd2, 5'b00010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
